soc_pif_bridge: RTL



---
 rtl/soc_pif_bridge.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/soc_pif_bridge.sv
// soc_pif_bridge: fans one 32-bit I/O master bus out to NUM_PERIPH peripherals.
// One transaction at a time. Peripherals may insert wait states via their ack.
// Unmapped selects and timeouts complete with an error response.
module soc_pif_bridge #(
   parameter int unsigned NUM_PERIPH = 8,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned SEL_W      = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [31:0]                  io_addr_i,
   input  logic [31:0]                  io_data_i,
   input  logic [3:0]                   io_wr_i,
   input  logic                         io_rd_i,
   output logic [31:0]                  io_data_o,
   output logic                         io_ack_o,
   output logic                         io_err_o,
   output logic                         io_busy_o,
   output logic [NUM_PERIPH*ADDR_W-1:0] periph_addr_o,
   output logic [NUM_PERIPH*32-1:0]     periph_data_o,
   output logic [NUM_PERIPH*4-1:0]      periph_wr_o,
   output logic [NUM_PERIPH-1:0]        periph_rd_o,
   input  logic [NUM_PERIPH*32-1:0]     periph_data_i,
   input  logic [NUM_PERIPH-1:0]        periph_ack_i
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned PA_W  = NUM_PERIPH * ADDR_W;
   localparam int unsigned PD_W  = NUM_PERIPH * 32;
   localparam int unsigned PW_W  = NUM_PERIPH * 4;

   typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [SEL_W-1:0]   r_sel;
   logic [SEL_W-1:0]   w_sel_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [PA_W-1:0]    r_paddr;
   logic [PA_W-1:0]    w_paddr_nxt;
   logic [PD_W-1:0]    r_pdata;
   logic [PD_W-1:0]    w_pdata_nxt;
   logic [PW_W-1:0]    r_pwr;
   logic [PW_W-1:0]    w_pwr_nxt;
   logic [NUM_PERIPH-1:0] r_prd;
   logic [NUM_PERIPH-1:0] w_prd_nxt;
   logic [31:0]        r_data;
   logic [31:0]        w_data_nxt;
   logic               r_ack;
   logic               w_ack_nxt;
   logic               r_err;
   logic               w_err_nxt;

   logic [SEL_W-1:0]   w_sel;
   logic               w_req;
   logic               w_mapped;
   logic               w_ack;
   logic [31:0]        w_rdata;
   logic               w_tmo;

   assign w_sel    = io_addr_i[ADDR_W+SEL_W-1:ADDR_W];
   assign w_req    = io_rd_i | (|io_wr_i);
   assign w_mapped = ({1'b0, w_sel} < (SEL_W+1)'(NUM_PERIPH));
   assign w_tmo    = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

   // Pick ack and read data of the latched peripheral; other acks are ignored.
   always_comb begin
      w_ack   = 1'b0;
      w_rdata = '0;
      for (int i = 0; i < int'(NUM_PERIPH); i++) begin
         if (r_sel == SEL_W'(i)) begin
            w_ack   = periph_ack_i[i];
            w_rdata = periph_data_i[i*32 +: 32];
         end
      end
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic: only mapped requests enter ACCESS.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_req && w_mapped) w_state_nxt = S_ACCESS;
         S_ACCESS: if (w_ack || w_tmo)    w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic: next values of strobes, response and timeout counter.
   always_comb begin
      w_sel_nxt   = r_sel;
      w_cnt_nxt   = '0;
      w_paddr_nxt = '0;
      w_pdata_nxt = '0;
      w_pwr_nxt   = '0;
      w_prd_nxt   = '0;
      w_data_nxt  = r_data;
      w_ack_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req && w_mapped) begin
               w_sel_nxt = w_sel;
               for (int i = 0; i < int'(NUM_PERIPH); i++) begin
                  if (w_sel == SEL_W'(i)) begin
                     w_paddr_nxt[i*ADDR_W +: ADDR_W] = io_addr_i[ADDR_W-1:0];
                     w_pdata_nxt[i*32 +: 32]         = io_data_i;
                     w_pwr_nxt[i*4 +: 4]             = io_wr_i;
                     w_prd_nxt[i]                    = io_rd_i;
                  end
               end
            end else if (w_req) begin
               w_ack_nxt  = 1'b1;
               w_err_nxt  = 1'b1;
               w_data_nxt = '0;
            end
         end
         S_ACCESS: begin
            if (w_ack) begin
               w_ack_nxt  = 1'b1;
               w_data_nxt = w_rdata;
            end else if (w_tmo) begin
               w_ack_nxt  = 1'b1;
               w_err_nxt  = 1'b1;
               w_data_nxt = '0;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
               w_paddr_nxt = r_paddr;
               w_pdata_nxt = r_pdata;
               w_pwr_nxt   = r_pwr;
               w_prd_nxt   = r_prd;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; async reset drops strobes immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sel   <= '0;
         r_cnt   <= '0;
         r_paddr <= '0;
         r_pdata <= '0;
         r_pwr   <= '0;
         r_prd   <= '0;
         r_data  <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_sel   <= w_sel_nxt;
         r_cnt   <= w_cnt_nxt;
         r_paddr <= w_paddr_nxt;
         r_pdata <= w_pdata_nxt;
         r_pwr   <= w_pwr_nxt;
         r_prd   <= w_prd_nxt;
         r_data  <= w_data_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign io_data_o     = r_data;
   assign io_ack_o      = r_ack;
   assign io_err_o      = r_err;
   assign io_busy_o     = (r_state == S_ACCESS);
   assign periph_addr_o = r_paddr;
   assign periph_data_o = r_pdata;
   assign periph_wr_o   = r_pwr;
   assign periph_rd_o   = r_prd;

endmodule
